// File: rtl/hwpe_ctrl_regfile_ctx.sv
// Multi-context register file: a ring of N_CONTEXT register images with a staging
// (write) context and an active (read) context, copy-forward on commit.
module hwpe_ctrl_regfile_ctx #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int N_CONTEXT  = 2,
   parameter int N_READ     = 2
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     clear,
   input  logic [N_READ-1:0]                        ReadEnable,
   input  logic [N_READ-1:0][ADDR_WIDTH-1:0]        ReadAddr,
   output logic [N_READ-1:0][DATA_WIDTH-1:0]        ReadData,
   input  logic                                     WriteEnable,
   input  logic [ADDR_WIDTH-1:0]                    WriteAddr,
   input  logic [DATA_WIDTH/8-1:0][7:0]             WriteData,
   input  logic [DATA_WIDTH/8-1:0]                  WriteBE,
   input  logic                                     commit,
   input  logic                                     release_ctx,
   output logic                                     full,
   output logic                                     empty,
   output logic [$clog2(N_CONTEXT+1)-1:0]           count,
   output logic [$clog2(N_CONTEXT)-1:0]             wr_ctx,
   output logic [$clog2(N_CONTEXT)-1:0]             rd_ctx,
   output logic [2**ADDR_WIDTH-1:0][DATA_WIDTH-1:0] MemContent
);

   localparam int NUM_BYTE = DATA_WIDTH / 8;
   localparam int N_WORDS  = 2**ADDR_WIDTH;
   localparam int CTX_W    = $clog2(N_CONTEXT);
   localparam int CNT_W    = $clog2(N_CONTEXT + 1);

   logic [DATA_WIDTH-1:0] mem     [N_CONTEXT][N_WORDS];
   logic [ADDR_WIDTH-1:0] raddr_q [N_READ];
   logic [DATA_WIDTH-1:0] staged  [N_WORDS];
   logic [DATA_WIDTH-1:0] wr_word;
   logic [CTX_W-1:0]      wr_next;
   logic [CNT_W-1:0]      count_next;
   logic                  commit_acc;
   logic                  release_acc;
   logic                  write_acc;
   logic                  copy_fwd;

   function automatic logic [CTX_W-1:0] ctx_inc(input logic [CTX_W-1:0] ctx);
      return (ctx == CTX_W'(N_CONTEXT - 1)) ? '0 : ctx + 1'b1;
   endfunction

   assign full  = (count == CNT_W'(N_CONTEXT));
   assign empty = (count == '0);

   // Acceptance is decided purely on the pre-edge occupancy; when full the
   // staging slot aliases the active context, so writes must be blocked.
   assign commit_acc  = commit & ~full;
   assign release_acc = release_ctx & ~empty;
   assign write_acc   = WriteEnable & ~full;
   assign count_next  = count + CNT_W'(commit_acc) - CNT_W'(release_acc);
   assign copy_fwd    = commit_acc && (count_next < CNT_W'(N_CONTEXT));
   assign wr_next     = ctx_inc(wr_ctx);

   always_comb begin
      wr_word = mem[wr_ctx][WriteAddr];
      for (int j = 0; j < NUM_BYTE; j++) begin
         if (WriteBE[j]) wr_word[j*8 +: 8] = WriteData[j];
      end
   end

   // Image of the committing context including this cycle's write, used as the
   // seed for the next staging context.
   always_comb begin
      for (int w = 0; w < N_WORDS; w++) begin
         staged[w] = mem[wr_ctx][w];
         if (write_acc && (ADDR_WIDTH'(w) == WriteAddr)) staged[w] = wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         for (int c = 0; c < N_CONTEXT; c++) begin
            for (int w = 0; w < N_WORDS; w++) begin
               mem[c][w] <= '0;
            end
         end
         for (int p = 0; p < N_READ; p++) begin
            raddr_q[p] <= '0;
         end
         wr_ctx <= '0;
         rd_ctx <= '0;
         count  <= '0;
      end else begin
         if (write_acc) mem[wr_ctx][WriteAddr] <= wr_word;
         if (copy_fwd) begin
            for (int w = 0; w < N_WORDS; w++) begin
               mem[wr_next][w] <= staged[w];
            end
         end
         if (commit_acc)  wr_ctx <= wr_next;
         if (release_acc) rd_ctx <= ctx_inc(rd_ctx);
         count <= count_next;
         for (int p = 0; p < N_READ; p++) begin
            if (ReadEnable[p]) raddr_q[p] <= ReadAddr[p];
         end
      end
   end

   always_comb begin
      for (int p = 0; p < N_READ; p++) begin
         ReadData[p] = mem[rd_ctx][raddr_q[p]];
      end
   end

   always_comb begin
      for (int w = 0; w < N_WORDS; w++) begin
         MemContent[w] = mem[rd_ctx][w];
      end
   end

endmodule

// File: tb/tb_hwpe_ctrl_regfile_ctx.sv
// Bench for hwpe_ctrl_regfile_ctx: a 2-context and a 3-context instance share one
// stimulus stream; each is compared every cycle against a context-ring model.
`timescale 1ns/1ps
module tb_hwpe_ctrl_regfile_ctx;
   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int NW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic clear = 1'b0;
   logic [NR-1:0] ren = '0;
   logic [NR-1:0][AW-1:0] raddr = '0;
   logic we = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [3:0][7:0] wdata = '0;
   logic [3:0] wbe = '0;
   logic commit = 1'b0;
   logic rel = 1'b0;

   logic [NR-1:0][DW-1:0] rdata0, rdata1;
   logic [NW-1:0][DW-1:0] mc0, mc1;
   logic full0, empty0, full1, empty1;
   logic [1:0] count0, count1;
   logic [0:0] wr0, rd0;
   logic [1:0] wr1, rd1;

   always #5 clk = ~clk;

   hwpe_ctrl_regfile_ctx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CONTEXT(2), .N_READ(NR)) dut2 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .ReadEnable(ren), .ReadAddr(raddr), .ReadData(rdata0),
      .WriteEnable(we), .WriteAddr(waddr), .WriteData(wdata), .WriteBE(wbe),
      .commit(commit), .release_ctx(rel),
      .full(full0), .empty(empty0), .count(count0),
      .wr_ctx(wr0), .rd_ctx(rd0), .MemContent(mc0)
   );

   hwpe_ctrl_regfile_ctx #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_CONTEXT(3), .N_READ(NR)) dut3 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .ReadEnable(ren), .ReadAddr(raddr), .ReadData(rdata1),
      .WriteEnable(we), .WriteAddr(waddr), .WriteData(wdata), .WriteBE(wbe),
      .commit(commit), .release_ctx(rel),
      .full(full1), .empty(empty1), .count(count1),
      .wr_ctx(wr1), .rd_ctx(rd1), .MemContent(mc1)
   );

   logic [31:0] o_cnt [2];
   logic [31:0] o_wr [2];
   logic [31:0] o_rd [2];
   logic [31:0] o_full [2];
   logic [31:0] o_empty [2];
   logic [NR-1:0][DW-1:0] o_rdata [2];
   logic [NW-1:0][DW-1:0] o_mc [2];

   always_comb begin
      o_cnt[0] = 32'(count0);  o_cnt[1] = 32'(count1);
      o_wr[0] = 32'(wr0);      o_wr[1] = 32'(wr1);
      o_rd[0] = 32'(rd0);      o_rd[1] = 32'(rd1);
      o_full[0] = 32'(full0);  o_full[1] = 32'(full1);
      o_empty[0] = 32'(empty0); o_empty[1] = 32'(empty1);
      o_rdata[0] = rdata0;     o_rdata[1] = rdata1;
      o_mc[0] = mc0;           o_mc[1] = mc1;
   end

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
   endfunction

   // Model: occupancy + active index; the staging slot is always active+occupancy mod N.
   int nctx [2] = '{2, 3};
   logic [DW-1:0] m_mem [2][3][NW];
   int m_rd [2];
   int m_cnt [2];
   logic [AW-1:0] m_raddr [2][NR];

   task automatic model_step(input int d);
      int n, wr, cn;
      bit ca, ra;
      logic [DW-1:0] word;
      n = nctx[d];
      if (!rst_n || clear) begin
         for (int c = 0; c < 3; c++)
            for (int w = 0; w < NW; w++) m_mem[d][c][w] = '0;
         for (int p = 0; p < NR; p++) m_raddr[d][p] = '0;
         m_rd[d] = 0;
         m_cnt[d] = 0;
         return;
      end
      wr = (m_rd[d] + m_cnt[d]) % n;
      ca = commit && (m_cnt[d] != n);
      ra = rel && (m_cnt[d] != 0);
      if (we && (m_cnt[d] != n)) begin
         word = m_mem[d][wr][waddr];
         for (int j = 0; j < 4; j++)
            if (wbe[j]) word[8*j +: 8] = wdata[j];
         m_mem[d][wr][waddr] = word;
      end
      cn = m_cnt[d] + int'(ca) - int'(ra);
      if (ca && cn < n)
         for (int w = 0; w < NW; w++) m_mem[d][(wr + 1) % n][w] = m_mem[d][wr][w];
      if (ra) m_rd[d] = (m_rd[d] + 1) % n;
      m_cnt[d] = cn;
      for (int p = 0; p < NR; p++)
         if (ren[p]) m_raddr[d][p] = raddr[p];
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("m_count[%0d]", d), o_cnt[d], 32'(m_cnt[d]));
            chk($sformatf("m_full[%0d]", d), o_full[d], 32'(m_cnt[d] == nctx[d]));
            chk($sformatf("m_empty[%0d]", d), o_empty[d], 32'(m_cnt[d] == 0));
            chk($sformatf("m_wr_ctx[%0d]", d), o_wr[d], 32'((m_rd[d] + m_cnt[d]) % nctx[d]));
            chk($sformatf("m_rd_ctx[%0d]", d), o_rd[d], 32'(m_rd[d]));
            for (int p = 0; p < NR; p++)
               chk($sformatf("m_rdata[%0d][%0d]", d, p), o_rdata[d][p],
                   m_mem[d][m_rd[d]][m_raddr[d][p]]);
            for (int w = 0; w < NW; w++)
               chk($sformatf("m_memcontent[%0d][%0d]", d, w), o_mc[d][w], m_mem[d][m_rd[d]][w]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic w, input logic [AW-1:0] a, input logic [31:0] dat,
                      input logic [3:0] be, input logic cm, input logic rl);
      we = w; waddr = a; wdata = dat; wbe = be; commit = cm; rel = rl;
      tick();
      we = 1'b0; wbe = '0; commit = 1'b0; rel = 1'b0;
   endtask

   function automatic int nonzero_words(input logic [NW-1:0][DW-1:0] mc);
      int n = 0;
      for (int w = 0; w < NW; w++) if (mc[w] != '0) n++;
      return n;
   endfunction

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset_count", o_cnt[0], 32'd0);
      chk("reset_empty", o_empty[0], 32'd1);
      chk("reset_full", o_full[0], 32'd0);
      chk("reset_rdata", o_rdata[0][0], 32'd0);
      chk("reset_memcontent", 32'(nonzero_words(mc0)), 32'd0);

      // Partial write committed in the same cycle, then read back with 1-cycle latency
      cyc(1, 5'd7, 32'hA5A5A5A5, 4'hF, 0, 0);
      cyc(1, 5'd3, 32'hDEADBEEF, 4'b0101, 1, 0);
      ren = 2'b11; raddr[0] = 5'd3; raddr[1] = 5'd7;
      tick();
      chk("be_commit_rdata0", o_rdata[0][0], 32'h00AD00EF);
      chk("be_commit_count", o_cnt[0], 32'd1);
      chk("be_commit_rdata1", o_rdata[0][1], 32'hA5A5A5A5);

      // Staging context seeded by copy-forward; partial write merges onto it
      cyc(1, 5'd7, 32'h000000CC, 4'b0001, 0, 0);
      cyc(1, 5'd3, 32'h11111111, 4'hF, 1, 0);
      chk("fill_full", o_full[0], 32'd1);
      chk("fill_count", o_cnt[0], 32'd2);

      // Write and commit while full are both ignored
      cyc(1, 5'd3, 32'hFFFFFFFF, 4'hF, 1, 0);
      chk("full_drop_count", o_cnt[0], 32'd2);
      chk("full_drop_rdata", o_rdata[0][0], 32'h00AD00EF);
      chk("n3_full_count", o_cnt[1], 32'd3);

      // Commit+release while full: release only
      cyc(0, 5'd0, 32'h0, 4'h0, 1, 1);
      chk("full_both_count", o_cnt[0], 32'd1);
      chk("full_both_rd_ctx", o_rd[0], 32'd1);
      chk("full_both_rdata0", o_rdata[0][0], 32'h11111111);
      chk("copy_fwd_rdata1", o_rdata[0][1], 32'hA5A5A5CC);

      // Reset with two contexts pending
      cyc(0, 5'd0, 32'h0, 4'h0, 1, 0);
      chk("pre_reset_count", o_cnt[0], 32'd2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("rst_empty", o_empty[0], 32'd1);
      chk("rst_count", o_cnt[0], 32'd0);
      chk("rst_memcontent", 32'(nonzero_words(mc0)), 32'd0);
      chk("rst_memcontent_n3", 32'(nonzero_words(mc1)), 32'd0);

      // Clear overrides a simultaneous write/commit/release
      cyc(1, 5'd3, 32'h12345678, 4'hF, 1, 0);
      cyc(0, 5'd0, 32'h0, 4'h0, 1, 0);
      chk("pre_clear_count", o_cnt[0], 32'd2);
      clear = 1'b1;
      cyc(1, 5'd3, 32'hCAFEF00D, 4'hF, 1, 1);
      clear = 1'b0;
      chk("clr_empty", o_empty[0], 32'd1);
      chk("clr_count", o_cnt[0], 32'd0);
      chk("clr_wr_ctx", o_wr[0], 32'd0);
      chk("clr_rd_ctx", o_rd[0], 32'd0);
      chk("clr_memcontent", 32'(nonzero_words(mc0)), 32'd0);

      // Three-context ring: wrap of the staging pointer, commit+release with two ports
      raddr[0] = 5'd1; raddr[1] = 5'd2;
      cyc(1, 5'd1, 32'h00000101, 4'hF, 1, 0);
      cyc(1, 5'd2, 32'h00000202, 4'hF, 1, 0);
      cyc(1, 5'd1, 32'h00000303, 4'hF, 1, 0);
      chk("n3_three_commit_count", o_cnt[1], 32'd3);
      chk("n3_wr_wrap", o_wr[1], 32'd0);
      chk("n3_full", o_full[1], 32'd1);
      cyc(0, 5'd0, 32'h0, 4'h0, 0, 1);
      chk("n3_release_rd_ctx", o_rd[1], 32'd1);
      cyc(1, 5'd2, 32'h00000404, 4'hF, 1, 1);
      chk("n3_both_count", o_cnt[1], 32'd2);
      chk("n3_both_rd_ctx", o_rd[1], 32'd2);
      chk("n3_both_wr_ctx", o_wr[1], 32'd1);
      chk("n3_both_rdata0", o_rdata[1][0], 32'h00000303);
      chk("n3_both_rdata1", o_rdata[1][1], 32'h00000202);
      cyc(0, 5'd0, 32'h0, 4'h0, 0, 1);
      chk("n3_last_count", o_cnt[1], 32'd1);
      chk("n3_last_rdata0", o_rdata[1][0], 32'h00000101);
      chk("n3_last_rdata1", o_rdata[1][1], 32'h00000404);

      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
